dec_onehot_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with a sequencing engine. It is the clocked successor of the combinational 2:4 decoder. It adds direct registered decode, an auto-scan mode that walks the one-hot output across all lines, and a timed one-shot pulse mode. It drives select or strobe lines, such as row enables, channel selects or LED scanning, from a single clock domain.

---
 rtl/dec_onehot_seq.sv | 120 ++++++++++++
 tb/tb_dec_onehot_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_onehot_seq.sv
// Registered N-to-2^N one-hot decoder with direct, auto-scan and timed one-shot pulse modes.
// All outputs are registers; the mode register is reloaded from `mode` on every enabled edge.
module dec_onehot_seq #(
  parameter int N    = 2,
  parameter int HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in,
  output logic [2**N-1:0]   out,
  output logic              out_valid,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W  = 2**N;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HMAX    = CW'(HOLD - 1);
  localparam logic [N-1:0]  IDX_MAX = '1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10,
    ST_PULSE  = 2'b11
  } state_t;

  state_t          state;
  state_t          mode_st;
  logic [CW-1:0]   hold_cnt;
  logic [N-1:0]    idx_inc;

  assign mode_st = state_t'(mode);
  assign idx_inc = idx + N'(1);

  function automatic logic [W-1:0] onehot(input logic [N-1:0] code);
    onehot       = '0;
    onehot[code] = 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      hold_cnt  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      idx       <= '0;
      wrap      <= 1'b0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else begin
      state <= mode_st;
      wrap  <= 1'b0;
      if (mode_st != state) begin
        // Entry edge: only the entry rules apply; in_valid is not sampled here.
        hold_cnt <= '0;
        idx      <= '0;
        if (mode_st == ST_SCAN) begin
          out       <= onehot('0);
          out_valid <= 1'b1;
        end else begin
          out       <= '0;
          out_valid <= 1'b0;
        end
      end else begin
        case (state)
          ST_OFF: begin
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
          end
          ST_DIRECT: begin
            if (in_valid) begin
              out       <= onehot(in);
              out_valid <= 1'b1;
              idx       <= in;
            end
          end
          ST_SCAN: begin
            if (hold_cnt == HMAX) begin
              hold_cnt <= '0;
              idx      <= idx_inc;
              out      <= onehot(idx_inc);
              wrap     <= (idx == IDX_MAX);
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
          ST_PULSE: begin
            // A new trigger wins over expiry of the running pulse.
            if (in_valid) begin
              out       <= onehot(in);
              out_valid <= 1'b1;
              idx       <= in;
              hold_cnt  <= '0;
            end else if (out_valid) begin
              if (hold_cnt == HMAX) begin
                out       <= '0;
                out_valid <= 1'b0;
                idx       <= '0;
                hold_cnt  <= '0;
              end else begin
                hold_cnt <= hold_cnt + CW'(1);
              end
            end
          end
          default: begin
            out       <= '0;
            out_valid <= 1'b0;
            idx       <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Bench for dec_onehot_seq: four parameterisations share one stimulus stream and are checked
// against a cycle-age/countdown reference model, plus table-driven and hand-written sequences.
`timescale 1ns/1ps
module tb_dec_onehot_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       in_valid;
  logic [2:0] in3;

  logic [3:0] out0, out1, out2;
  logic [7:0] out3;
  logic [1:0] idx0, idx1, idx2;
  logic [2:0] idx3;
  logic       vld0, vld1, vld2, vld3;
  logic       wrap0, wrap1, wrap2, wrap3;

  dec_onehot_seq #(.N(2), .HOLD(1)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in(in3[1:0]), .out(out0), .out_valid(vld0), .idx(idx0), .wrap(wrap0));
  dec_onehot_seq #(.N(2), .HOLD(3)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in(in3[1:0]), .out(out1), .out_valid(vld1), .idx(idx1), .wrap(wrap1));
  dec_onehot_seq #(.N(2), .HOLD(4)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in(in3[1:0]), .out(out2), .out_valid(vld2), .idx(idx2), .wrap(wrap2));
  dec_onehot_seq #(.N(3), .HOLD(1)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in_valid(in_valid), .in(in3), .out(out3), .out_valid(vld3), .idx(idx3), .wrap(wrap3));

  logic [7:0] o_out [4];
  logic [2:0] o_idx [4];
  logic       o_vld [4];
  logic       o_wrap[4];

  assign o_out[0] = {4'b0, out0};
  assign o_out[1] = {4'b0, out1};
  assign o_out[2] = {4'b0, out2};
  assign o_out[3] = out3;
  assign o_idx[0] = {1'b0, idx0};
  assign o_idx[1] = {1'b0, idx1};
  assign o_idx[2] = {1'b0, idx2};
  assign o_idx[3] = idx3;
  assign o_vld[0] = vld0;
  assign o_vld[1] = vld1;
  assign o_vld[2] = vld2;
  assign o_vld[3] = vld3;
  assign o_wrap[0] = wrap0;
  assign o_wrap[1] = wrap1;
  assign o_wrap[2] = wrap2;
  assign o_wrap[3] = wrap3;

  int nn [4] = '{2, 2, 2, 3};
  int hh [4] = '{1, 3, 4, 1};

  // Reference model: mode tracking, scan age since entry, pulse countdown, last direct code.
  int cur [4];
  int age [4];
  int left[4];
  int pcode[4];
  int dcode[4];
  int dval[4];
  int mwrap[4];
  int tl, tc;

  int nvec = 0;
  int nbad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        cur[i] = 0; age[i] = 0; left[i] = 0; pcode[i] = 0;
        dcode[i] = 0; dval[i] = 0; mwrap[i] = 0;
      end else if (!en) begin
        mwrap[i] = 0;
      end else begin
        tl = 1 << nn[i];
        tc = int'(in3) % tl;
        mwrap[i] = 0;
        if (int'(mode) != cur[i]) begin
          cur[i] = int'(mode); age[i] = 0; left[i] = 0; dval[i] = 0;
        end else begin
          case (cur[i])
            1: if (in_valid) begin dcode[i] = tc; dval[i] = 1; end
            2: begin
              age[i]++;
              mwrap[i] = (age[i] % (hh[i] * tl) == 0) ? 1 : 0;
            end
            3: begin
              if (in_valid) begin left[i] = hh[i]; pcode[i] = tc; end
              else if (left[i] > 0) left[i]--;
            end
            default: ;
          endcase
        end
      end
    end
  end

  function automatic int e_idx(int i);
    int l;
    l = 1 << nn[i];
    case (cur[i])
      1: return (dval[i] != 0) ? dcode[i] : 0;
      2: return (age[i] / hh[i]) % l;
      3: return (left[i] > 0) ? pcode[i] : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] e_out(int i);
    logic [7:0] one;
    one = 8'd1;
    case (cur[i])
      1: return (dval[i] != 0) ? (one << dcode[i]) : 8'd0;
      2: return one << e_idx(i);
      3: return (left[i] > 0) ? (one << pcode[i]) : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic check(string nm);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] eo;
      logic [2:0] ei;
      logic       ew;
      eo = e_out(i);
      ei = 3'(e_idx(i));
      ew = (mwrap[i] != 0);
      nvec++;
      if (o_out[i] !== eo || o_vld[i] !== (eo != 8'd0) || o_idx[i] !== ei || o_wrap[i] !== ew) begin
        nbad++;
        $display("FAIL %s u%0d: out=%h vld=%b idx=%0d wrap=%b, expected out=%h vld=%b idx=%0d wrap=%b",
                 nm, i, o_out[i], o_vld[i], o_idx[i], o_wrap[i], eo, (eo != 8'd0), ei, ew);
      end
    end
  endtask

  task automatic expect_eq(string nm, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(string nm);
    @(posedge clk);
    @(negedge clk);
    check(nm);
  endtask

  typedef struct {
    logic [1:0] m;
    logic       v;
    logic [2:0] code;
    logic [7:0] exp2;
    logic [7:0] exp3;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{2'd1, 1'b0, 3'd0, 8'h00, 8'h00};
    tbl[1] = '{2'd1, 1'b1, 3'd0, 8'h01, 8'h01};
    tbl[2] = '{2'd1, 1'b1, 3'd1, 8'h02, 8'h02};
    tbl[3] = '{2'd1, 1'b1, 3'd2, 8'h04, 8'h04};
    tbl[4] = '{2'd1, 1'b1, 3'd3, 8'h08, 8'h08};
    tbl[5] = '{2'd1, 1'b0, 3'd1, 8'h08, 8'h08};
    tbl[6] = '{2'd1, 1'b0, 3'd2, 8'h08, 8'h08};
    tbl[7] = '{2'd1, 1'b1, 3'd7, 8'h08, 8'h80};
    tbl[8] = '{2'd1, 1'b0, 3'd5, 8'h08, 8'h80};
    tbl[9] = '{2'd1, 1'b1, 3'd4, 8'h01, 8'h10};

    rst_n = 1'b1; en = 1'b1; mode = 2'd0; in_valid = 1'b0; in3 = 3'd0;

    // Asynchronous reset mid-cycle, then OFF for 10 cycles.
    #3 rst_n = 1'b0;
    #1;
    check("reset_async");
    expect_eq("reset_out", o_out[3], 8'h00);
    expect_eq("reset_wrap", {7'b0, o_wrap[0]}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      cyc("off");
      expect_eq("off_out", o_out[0], 8'h00);
    end

    // DIRECT table.
    for (int r = 0; r < 10; r++) begin
      mode = tbl[r].m; in_valid = tbl[r].v; in3 = tbl[r].code;
      cyc("direct");
      expect_eq("direct_tbl_n2", o_out[0], tbl[r].exp2);
      expect_eq("direct_tbl_n3", o_out[3], tbl[r].exp3);
    end

    // SCAN, HOLD=3 on u1.
    in_valid = 1'b0; mode = 2'd0;
    cyc("to_off");
    mode = 2'd2;
    for (int k = 0; k < 26; k++) begin
      cyc("scan");
      expect_eq("scan_h3_out", o_out[1], 8'd1 << ((k / 3) % 4));
      expect_eq("scan_h3_wrap", {7'b0, o_wrap[1]}, (k == 12 || k == 24) ? 8'd1 : 8'd0);
    end

    // Enable freeze on u0 (HOLD=1) at idx=2.
    mode = 2'd0;
    cyc("to_off");
    mode = 2'd2;
    cyc("freeze_entry");
    cyc("freeze_i1");
    cyc("freeze_i2");
    expect_eq("freeze_pre", o_out[0], 8'h04);
    en = 1'b0;
    repeat (5) begin
      cyc("freeze");
      expect_eq("freeze_out", o_out[0], 8'h04);
      expect_eq("freeze_wrap", {7'b0, o_wrap[0]}, 8'h00);
    end
    en = 1'b1;
    cyc("resume");
    expect_eq("resume_out", o_out[0], 8'h08);
    cyc("resume_wrap");
    expect_eq("resume_wrap_out", o_out[0], 8'h01);
    expect_eq("resume_wrap_flag", {7'b0, o_wrap[0]}, 8'h01);

    // PULSE, HOLD=4 on u2: plain pulse then retrigger on the 3rd pulse cycle.
    mode = 2'd3;
    cyc("pulse_entry");
    expect_eq("pulse_entry_out", o_out[2], 8'h00);
    in3 = 3'd2; in_valid = 1'b1;
    cyc("pulse_trig");
    expect_eq("pulse_c1", o_out[2], 8'h04);
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      cyc("pulse");
      expect_eq("pulse_width", o_out[2], (k <= 4) ? 8'h04 : 8'h00);
    end
    in3 = 3'd2; in_valid = 1'b1;
    cyc("retrig_a");
    expect_eq("retrig_c1", o_out[2], 8'h04);
    in_valid = 1'b0;
    cyc("retrig_b");
    expect_eq("retrig_c2", o_out[2], 8'h04);
    cyc("retrig_c");
    expect_eq("retrig_c3", o_out[2], 8'h04);
    in3 = 3'd1; in_valid = 1'b1;
    cyc("retrig_d");
    expect_eq("retrig_new1", o_out[2], 8'h02);
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      cyc("retrig");
      expect_eq("retrig_width", o_out[2], (k <= 4) ? 8'h02 : 8'h00);
    end

    // N=3 scan, HOLD=1: 8 distinct codes then wrap.
    mode = 2'd0;
    cyc("to_off");
    mode = 2'd2;
    cyc("scan3_entry");
    expect_eq("scan3_first", o_out[3], 8'h01);
    for (int k = 1; k <= 8; k++) begin
      cyc("scan3");
      expect_eq("scan3_out", o_out[3], 8'd1 << (k % 8));
      expect_eq("scan3_wrap", {7'b0, o_wrap[3]}, (k == 8) ? 8'd1 : 8'd0);
    end

    // Reset in the middle of a scan; release re-enters SCAN at line 0.
    cyc("scan3_more");
    #2 rst_n = 1'b0;
    #1;
    check("reset_midscan");
    expect_eq("reset_midscan_out", o_out[1], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rescan");
    expect_eq("rescan_u0", o_out[0], 8'h01);
    expect_eq("rescan_u1", o_out[1], 8'h01);

    // Randomised stream against the reference model.
    for (int n = 0; n < 3000; n++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 2) == 0);
      in3      = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cyc("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
